// File: rtl/sine_pwm_dac.sv
// Double-buffered PWM DAC for signed samples, with ready/valid pacing and a period-start strobe.
// Define SINE_PWM_UNDERRUN_EN to build the sticky underrun flag; otherwise underrun is tied low.
module sine_pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

  localparam logic [15:0]      PRE_MAX  = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

  logic [15:0]      pre_cnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic [WIDTH-1:0] duty;
  logic             tick;
  logic             boundary;
  logic             transfer;

  assign tick         = (pre_cnt == PRE_MAX);
  assign boundary     = tick && (cnt == CNT_MAX);
  assign sample_ready = ~shadow_full & ~reset;
  assign transfer     = sample_valid & sample_ready;
  // Offset-binary: flipping the sign bit adds half-scale modulo 2^WIDTH.
  assign duty         = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      active       <= MIDSCALE;
      shadow       <= '0;
      shadow_full  <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      pre_cnt      <= tick ? '0 : pre_cnt + 16'd1;
      if (tick) cnt <= cnt + WIDTH'(1);
      pwm_out      <= (cnt < active);
      period_start <= boundary;

      if (boundary) begin
        if (shadow_full) begin
          active      <= shadow;
          shadow_full <= 1'b0;
        end else if (transfer) begin
          active <= duty;
        end
      end else if (transfer) begin
        shadow      <= duty;
        shadow_full <= 1'b1;
      end
    end
  end

`ifdef SINE_PWM_UNDERRUN_EN
  logic underrun_q;

  // A new underrun on this edge takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (boundary && !shadow_full && !transfer) begin
      underrun_q <= 1'b1;
    end else if (underrun_clr) begin
      underrun_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_clr;
  assign unused_clr = underrun_clr;
  assign underrun   = 1'b0;
`endif

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Self-checking bench: two DUTs (PRESCALE 1 and 3) share stimulus and are compared every cycle
// against a period-level reference model, plus table-driven duty measurements and corner sequences.
module tb_sine_pwm_dac;

  localparam int NPER = 256;
`ifdef SINE_PWM_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_r;
  logic       valid_r;
  logic       clr_r;
  logic [7:0] sample_r;
  logic       ready1, pwm1, ps1, ur1;
  logic       ready3, pwm3, ps3, ur3;

  always #5 clk = ~clk;

  sine_pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset_r), .sample_in(sample_r), .sample_valid(valid_r),
    .sample_ready(ready1), .underrun_clr(clr_r), .pwm_out(pwm1),
    .period_start(ps1), .underrun(ur1)
  );

  sine_pwm_dac #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset_r), .sample_in(sample_r), .sample_valid(valid_r),
    .sample_ready(ready3), .underrun_clr(clr_r), .pwm_out(pwm3),
    .period_start(ps3), .underrun(ur3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time position within the period, current duty, one-deep pending slot.
  typedef struct {
    int t;
    int duty;
    bit pend;
    int pend_val;
    bit pwm;
    bit ps;
    bit ur;
  } model_t;

  model_t m [2];

  function automatic int pre_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_step(input int i);
    int per, sv, conv;
    bit last, xfer, set_ur;
    per = pre_of(i) * NPER;
    if (reset_r) begin
      m[i].t = 0; m[i].duty = 128; m[i].pend = 0; m[i].pend_val = 0;
      m[i].pwm = 0; m[i].ps = 0; m[i].ur = 0;
    end else begin
      sv     = $signed(sample_r);
      conv   = (sv + 128) % 256;
      last   = (m[i].t == per - 1);
      xfer   = valid_r && !m[i].pend;
      set_ur = 0;
      m[i].pwm = (m[i].t / pre_of(i)) < m[i].duty;
      if (last) begin
        if (m[i].pend) begin
          m[i].duty = m[i].pend_val;
          m[i].pend = 0;
        end else if (xfer) begin
          m[i].duty = conv;
        end else begin
          set_ur = 1;
        end
      end else if (xfer) begin
        m[i].pend     = 1;
        m[i].pend_val = conv;
      end
      if (set_ur) m[i].ur = 1;
      else if (clr_r) m[i].ur = 0;
      m[i].ps = last;
      m[i].t  = (m[i].t + 1) % per;
    end
  endtask

  function automatic logic [3:0] exp_vec(input int i);
    return {~m[i].pend & ~reset_r, m[i].pwm, m[i].ps, UR_EN & m[i].ur};
  endfunction

  task automatic cycle(input logic v, input logic [7:0] s, input logic c);
    valid_r  = v;
    sample_r = s;
    clr_r    = c;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("dut1 {ready,pwm,ps,ur}", {ready1, pwm1, ps1, ur1}, exp_vec(0));
    check("dut3 {ready,pwm,ps,ur}", {ready3, pwm3, ps3, ur3}, exp_vec(1));
  endtask

  task automatic wait_ps(input int i, input int max_cyc);
    int k;
    k = 0;
    while (((i == 0) ? ps1 : ps3) !== 1'b1 && k < max_cyc) begin
      cycle(1'b0, 8'h00, 1'b0);
      k++;
    end
    check($sformatf("period_start dut%0d within budget", pre_of(i)), (i == 0) ? ps1 : ps3, 1);
  endtask

  task automatic measure(input int i, input logic v0, input logic [7:0] s0,
                         output int hi, output int ps_cnt);
    hi = 0;
    ps_cnt = 0;
    for (int k = 0; k < pre_of(i) * NPER; k++) begin
      cycle((k == 0) ? v0 : 1'b0, s0, 1'b0);
      hi     += int'((i == 0) ? pwm1 : pwm3);
      ps_cnt += int'((i == 0) ? ps1 : ps3);
    end
  endtask

  typedef struct {
    logic [7:0] sample;
    int         exp_hi;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int hi, pc, idx, acc, glitch;
    bit seen_low, rdy_before, v;
    logic [7:0] s_next;
    logic [7:0] vals [3];
    int exp_p [4];

    tbl[0] = '{8'h80, 0};
    tbl[1] = '{8'h7F, 255};
    tbl[2] = '{8'hFF, 127};
    tbl[3] = '{8'h01, 129};
    tbl[4] = '{8'h40, 192};
    tbl[5] = '{8'hC0, 64};
    tbl[6] = '{8'h20, 160};

    reset_r = 1'b1; valid_r = 1'b0; clr_r = 1'b0; sample_r = 8'h00;
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
    check("reset pwm_out", pwm1, 0);
    check("reset sample_ready", ready1, 0);
    check("reset period_start", ps1, 0);
    check("reset underrun", ur1, 0);

    // Idle after reset: midscale duty, underrun after first boundary.
    reset_r = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    check("ready after reset release", ready1, 1);
    wait_ps(0, 300);
    check("underrun after idle boundary", ur1, UR_EN);
    measure(0, 1'b1, tbl[0].sample, hi, pc);
    check("idle period high clocks", hi, 128);
    check("idle period start pulses", pc, 1);

    // One sample per period: each lands in the following period.
    for (int i = 0; i < 7; i++) begin
      if (i + 1 < 7) s_next = tbl[i + 1].sample;
      else s_next = 8'h00;
      measure(0, (i + 1 < 7), s_next, hi, pc);
      check($sformatf("duty for sample 0x%02h", tbl[i].sample), hi, tbl[i].exp_hi);
      check("period_start once per period", pc, 1);
    end

    // Continuous valid: one accept per period, clean single pulse per period.
    vals[0] = 8'h00; vals[1] = 8'h40; vals[2] = 8'hC0;
    exp_p[0] = 160; exp_p[1] = 128; exp_p[2] = 192; exp_p[3] = 64;
    idx = 0;
    for (int p = 0; p < 4; p++) begin
      hi = 0; acc = 0; glitch = 0; seen_low = 0;
      for (int k = 0; k < NPER; k++) begin
        v = (idx < 3);
        rdy_before = ready1;
        cycle(v, v ? vals[idx] : 8'h00, 1'b0);
        if (v && rdy_before) begin
          acc++;
          idx++;
        end
        hi += int'(pwm1);
        if (!pwm1) seen_low = 1;
        else if (seen_low) glitch++;
      end
      check($sformatf("streaming period %0d high clocks", p), hi, exp_p[p]);
      check($sformatf("streaming period %0d accepts", p), acc, (p < 3) ? 1 : 0);
      check($sformatf("streaming period %0d glitches", p), glitch, 0);
    end

    // Bypass: valid on the boundary cycle with an empty shadow.
    hi = 0;
    cycle(1'b0, 8'h00, 1'b1);
    hi += int'(pwm1);
    check("underrun cleared", ur1, 0);
    for (int k = 1; k < NPER - 1; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      hi += int'(pwm1);
    end
    cycle(1'b1, 8'h20, 1'b0);
    hi += int'(pwm1);
    check("pre-bypass period high clocks", hi, 64);
    check("period_start after bypass", ps1, 1);
    check("underrun stays 0 on bypass", ur1, 0);
    check("shadow empty after bypass", ready1, 1);
    measure(0, 1'b0, 8'h00, hi, pc);
    check("bypass period high clocks", hi, 160);
    check("underrun after empty boundary", ur1, UR_EN);

    // Reset mid-period with duty 200 and a pending sample.
    measure(0, 1'b1, 8'h48, hi, pc);
    check("period before duty 200", hi, 160);
    cycle(1'b1, 8'h7F, 1'b0);
    repeat (99) cycle(1'b0, 8'h00, 1'b0);
    check("pwm high at cnt 100 duty 200", pwm1, 1);
    reset_r = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    check("pwm low after mid reset", pwm1, 0);
    check("ready low during reset", ready1, 0);
    reset_r = 1'b0;
    measure(0, 1'b0, 8'h00, hi, pc);
    check("first period after mid reset", hi, 128);
    check("period_start after mid reset", pc, 1);
    measure(0, 1'b0, 8'h00, hi, pc);
    check("pending sample discarded", hi, 128);

    // PRESCALE=3 instance: 768-clk periods, underrun clear and set-wins.
    wait_ps(1, 800);
    measure(1, 1'b1, 8'h00, hi, pc);
    check("dut3 midscale high clocks", hi, 384);
    check("dut3 period_start per 768 clk", pc, 1);
    measure(1, 1'b1, 8'h40, hi, pc);
    check("dut3 sample 0x00 high clocks", hi, 384);
    measure(1, 1'b0, 8'h00, hi, pc);
    check("dut3 sample 0x40 high clocks", hi, 576);
    check("dut3 underrun set", ur3, UR_EN);
    cycle(1'b0, 8'h00, 1'b1);
    check("dut3 underrun cleared", ur3, 0);
    repeat (766) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("dut3 boundary with clear", ps3, 1);
    check("dut3 underrun set wins over clear", ur3, UR_EN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
